ysyx_22050854_operand_fetch: RTL
================================

# ysyx_22050854_operand_fetch

Read side of the 32×64 integer register file. Accepts decoded instructions from the decode stage, drives the register file's two combinational read address ports, and tracks in-flight writers with a busy-bit scoreboard. It stalls on RAW/WAW hazards, optionally bypasses the writeback value, and registers the operands into a valid/ready output slot feeding execute.

## Interface
Parameters:
- XLEN, 64, data width
- REG_AW, 5, register address width (32 registers, x0 hardwired zero)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash: drop output slot, clear scoreboard
- in_valid  in  1  decode has an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs1, in_rs2  in  REG_AW  source registers
- in_rd  in  REG_AW  destination register
- in_rd_wen  in  1  instruction writes in_rd
- in_pc  in  XLEN  passed through
- rf_raddra, rf_raddrb  out  REG_AW  register file read addresses, equal to in_rs1/in_rs2 combinationally
- rf_rdata1, rf_rdata2  in  XLEN  register file read data (0 for x0)
- wb_valid, wb_wen  in  1  writeback event (same cycle as the register file write)
- wb_rd  in  REG_AW  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  output slot full
- out_ready  in  1  execute consumes slot
- out_rs1_val, out_rs2_val  out  XLEN  operands
- out_rd, out_rd_wen, out_pc  out  —  registered copies

## Operation
- Scoreboard holds busy[31:0]; busy[0] is constant 0.
- Writeback clear: wb_valid && wb_wen && wb_rd != 0 clears busy[wb_rd].
- Accept set: when in_rd_wen && in_rd != 0, acceptance sets busy[in_rd]. If a clear and a set hit the same register in one cycle, the set wins.
- Forward match for source s: wb_valid && wb_wen && wb_rd == s && s != 0.
- RAW hazard on source s: s != 0 && busy[s] && !forward match (with forwarding compiled out, a forward match does not exempt).
- WAW hazard: in_rd_wen && in_rd != 0 && busy[in_rd] && !(clear of in_rd this cycle).
- in_ready = !flush && no RAW(rs1) && no RAW(rs2) && no WAW && (!out_valid || out_ready).
- Operand select, on acceptance:
  - forward match → wb_data
  - x0 → 0
  - otherwise → rf_rdataN
- On acceptance, the output slot loads all fields and out_valid goes to 1.
- Slot drain: out_valid && out_ready && no acceptance → out_valid goes to 0.
- While out_valid && !out_ready, output fields hold steady.
- flush (priority over all):
  - next cycle out_valid = 0 and busy = 0
  - in_ready = 0 during flush
  - writebacks arriving during flush are ignored
  - the caller asserts flush only when every in-flight writer is squashed

## Timing
- Reset: out_valid = 0; out_rs1_val, out_rs2_val, out_rd, out_rd_wen, out_pc = 0; busy all 0.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction per cycle when hazard-free and out_ready held high.
- Producer-to-consumer spacing:
  - Forwarding in: a dependent instruction presented in the writeback cycle is accepted that cycle.
  - Forwarding out: it is accepted the cycle after the writeback, when the register file already holds the value.
- Reset asserted mid-stall: the slot and scoreboard clear immediately (asynchronous); nothing is retained.
- in_ready is combinational from inputs and state; out_* are registered only.

## Configuration
- Macro YSYX_22050854_OPFWD_EN.
- Defined: the writeback bypass mux and the forward-match hazard exemption are present.
- Undefined: no bypass. Operands come only from the register file or 0, and RAW hazards stall until busy clears, costing 1 extra cycle per writeback-dependent instruction. WAW same-cycle clear/set behaviour is unchanged.

## Structure
- Package ysyx_22050854_pkg holds XLEN, REG_AW, NREG = 32, and the operand-select enum (SRC_RF, SRC_WB, SRC_ZERO).
- Sub-module ysyx_22050854_scoreboard holds busy bits, set/clear/flush, and two read ports plus a WAW query port.
- The top level contains the hazard logic, operand mux, and output slot.

## Test plan
- Reset, then accept {rs1=0, rs2=0, rd=5, pc=0x80000000} → next cycle out_valid=1, operands 0, out_pc 0x80000000; busy[5]=1.
- RAW with forwarding:
  - Stimulus: instruction with rs1=5 while busy[5]; wb {rd=5, data=0x1234} in the same cycle.
  - Defined: accepted that cycle, out_rs1_val=0x1234.
  - Undefined: in_ready=0 that cycle, accepted the next cycle with the register file value 0x1234.
- WAW: rd=7 busy with no writeback → in_ready=0 indefinitely; wb rd=7 → accepted that cycle, busy[7] remains 1.
- Backpressure: out_ready=0 with slot full → in_ready=0, out fields stable 3 cycles; out_ready=1 → next instruction loads the following cycle.
- Flush with slot full and busy{3,9} → next cycle out_valid=0, busy all 0, and an instruction using rs1=3 is accepted immediately.
- x0 handling: rd=0 with in_rd_wen=1 never sets busy; wb rd=0 with data 0xFFFF → a consumer reading rs1=0 gets 0.

Source files
------------

// File: rtl/ysyx_22050854_pkg.sv
// Shared widths and operand-source encoding for the operand-fetch stage.
package ysyx_22050854_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 32;

    typedef enum logic [1:0] {
        SRC_RF   = 2'd0,
        SRC_WB   = 2'd1,
        SRC_ZERO = 2'd2
    } src_sel_e;

endpackage

// File: rtl/ysyx_22050854_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, x0 never busy.
// Same-cycle clear and set on one register resolves to set.
module ysyx_22050854_scoreboard
    import ysyx_22050854_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_addr,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_addr,
    input  logic [REG_AW-1:0] i_rd_addr1,
    input  logic [REG_AW-1:0] i_rd_addr2,
    input  logic [REG_AW-1:0] i_waw_addr,
    output logic              o_busy1_c,
    output logic              o_busy2_c,
    output logic              o_busy_waw_c
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
        if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_busy <= '0;
        else if (i_flush) r_busy <= '0;
        else              r_busy <= w_busy_nxt;
    end

    assign o_busy1_c    = r_busy[i_rd_addr1];
    assign o_busy2_c    = r_busy[i_rd_addr2];
    assign o_busy_waw_c = r_busy[i_waw_addr];

endmodule

// File: rtl/ysyx_22050854_operand_fetch.sv
// Operand fetch: hazard stall, optional writeback bypass, registered output slot.
// Bypass is enabled by defining YSYX_22050854_OPFWD_EN.
module ysyx_22050854_operand_fetch #(
    parameter int unsigned XLEN   = ysyx_22050854_pkg::XLEN,
    parameter int unsigned REG_AW = ysyx_22050854_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_wen,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rf_raddra,
    output logic [REG_AW-1:0] rf_raddrb,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_wen,
    output logic [XLEN-1:0]   out_pc
);

    import ysyx_22050854_pkg::*;

    logic              w_wb_hit;
    logic              w_fwd1;
    logic              w_fwd2;
    logic              w_busy1;
    logic              w_busy2;
    logic              w_busy_waw;
    logic              w_raw1;
    logic              w_raw2;
    logic              w_waw;
    logic              w_accept;
    src_sel_e          w_sel1;
    src_sel_e          w_sel2;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;

    logic              r_valid;
    logic [XLEN-1:0]   r_rs1_val;
    logic [XLEN-1:0]   r_rs2_val;
    logic [REG_AW-1:0] r_rd;
    logic              r_rd_wen;
    logic [XLEN-1:0]   r_pc;

    assign rf_raddra = in_rs1;
    assign rf_raddrb = in_rs2;

    assign w_wb_hit = wb_valid && wb_wen && (wb_rd != '0);

`ifdef YSYX_22050854_OPFWD_EN
    assign w_fwd1 = w_wb_hit && (wb_rd == in_rs1);
    assign w_fwd2 = w_wb_hit && (wb_rd == in_rs2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    ysyx_22050854_scoreboard u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush),
        .i_clr_en     (w_wb_hit),
        .i_clr_addr   (wb_rd),
        .i_set_en     (w_accept && in_rd_wen),
        .i_set_addr   (in_rd),
        .i_rd_addr1   (in_rs1),
        .i_rd_addr2   (in_rs2),
        .i_waw_addr   (in_rd),
        .o_busy1_c    (w_busy1),
        .o_busy2_c    (w_busy2),
        .o_busy_waw_c (w_busy_waw)
    );

    // A writeback landing this cycle frees its register for a new writer.
    assign w_raw1 = (in_rs1 != '0) && w_busy1 && !w_fwd1;
    assign w_raw2 = (in_rs2 != '0) && w_busy2 && !w_fwd2;
    assign w_waw  = in_rd_wen && (in_rd != '0) && w_busy_waw
                    && !(w_wb_hit && (wb_rd == in_rd));

    assign in_ready = !flush && !w_raw1 && !w_raw2 && !w_waw
                      && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_sel1 = SRC_RF;
        w_sel2 = SRC_RF;
        if (w_fwd1)               w_sel1 = SRC_WB;
        else if (in_rs1 == '0)    w_sel1 = SRC_ZERO;
        if (w_fwd2)               w_sel2 = SRC_WB;
        else if (in_rs2 == '0)    w_sel2 = SRC_ZERO;
    end

    always_comb begin
        w_op1 = rf_rdata1;
        w_op2 = rf_rdata2;
        case (w_sel1)
            SRC_WB:   w_op1 = wb_data;
            SRC_ZERO: w_op1 = '0;
            default:  w_op1 = rf_rdata1;
        endcase
        case (w_sel2)
            SRC_WB:   w_op2 = wb_data;
            SRC_ZERO: w_op2 = '0;
            default:  w_op2 = rf_rdata2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_rd      <= '0;
            r_rd_wen  <= 1'b0;
            r_pc      <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_rs1_val <= w_op1;
            r_rs2_val <= w_op2;
            r_rd      <= in_rd;
            r_rd_wen  <= in_rd_wen;
            r_pc      <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_rs1_val = r_rs1_val;
    assign out_rs2_val = r_rs2_val;
    assign out_rd      = r_rd;
    assign out_rd_wen  = r_rd_wen;
    assign out_pc      = r_pc;

endmodule
